// File: rtl/gain_pkg.sv
// Shared constants and helpers for the gain coefficient bank:
// unity value, write saturation and the register address map.
package gain_pkg;

  // Unity gain in ufi(w, w/2) format.
  function automatic logic [31:0] unity(input int w);
    return 32'd1 << (w / 2);
  endfunction

  // Clamp a 32-bit bus write to w bits; any set bit above w saturates to all ones.
  function automatic logic [31:0] sat32(input logic [31:0] data, input int w);
    logic [31:0] mask;
    logic [31:0] res;
    if (w >= 32) begin
      mask = 32'hFFFF_FFFF;
    end else begin
      mask = (32'd1 << w) - 32'd1;
    end
    if ((w < 32) && ((data >> w) != 32'd0)) begin
      res = mask;
    end else begin
      res = data & mask;
    end
    return res;
  endfunction

  function automatic int tgt_base();
    return 0;
  endfunction

  function automatic int live_base(input int ch_num);
    return ch_num;
  endfunction

  function automatic int step_addr(input int ch_num);
    return 2 * ch_num;
  endfunction

  function automatic int status_addr(input int ch_num);
    return 2 * ch_num + 1;
  endfunction

endpackage

// File: rtl/gain_ramp_ch.sv
// One channel's live coefficient: snaps to target when step is zero,
// otherwise moves by at most step toward target on each sample tick.
module gain_ramp_ch
  import gain_pkg::*;
#(
  parameter int COEF_WDT = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [COEF_WDT-1:0] target,
  input  logic [COEF_WDT-1:0] step,
  input  logic                smpTick,
  output logic [COEF_WDT-1:0] live,
  output logic                busy
);

  localparam logic [COEF_WDT-1:0] UNITY_C = COEF_WDT'(unity(COEF_WDT));

  logic [COEF_WDT-1:0] live_q;
  logic [COEF_WDT-1:0] live_d;
  logic [COEF_WDT:0]   diff_s;
  logic [COEF_WDT-1:0] mag_s;

  // Next live value; the extra diff bit gives the direction, so no step can overshoot or wrap.
  always_comb begin
    diff_s = {1'b0, target} - {1'b0, live_q};
    if (diff_s[COEF_WDT]) begin
      mag_s = live_q - target;
    end else begin
      mag_s = diff_s[COEF_WDT-1:0];
    end
    live_d = live_q;
    if (step == '0) begin
      live_d = target;
    end else if (smpTick) begin
      if (mag_s <= step) begin
        live_d = target;
      end else if (diff_s[COEF_WDT]) begin
        live_d = live_q - step;
      end else begin
        live_d = live_q + step;
      end
    end else begin
      live_d = live_q;
    end
  end

  // Live coefficient register.
  always_ff @(posedge clk) begin
    if (reset) begin
      live_q <= UNITY_C;
    end else begin
      live_q <= live_d;
    end
  end

  assign live = live_q;
  assign busy = (live_q != target);

endmodule

// File: rtl/gain_avs_ramp.sv
// Avalon-MM bank of per-channel gain targets plus a shared ramp step;
// each channel's live coefficient ramps toward its target on sample ticks.
module gain_avs_ramp
  import gain_pkg::*;
#(
  parameter  int COEF_WDT = 16,
  parameter  int CH_NUM   = 4,
  localparam int AW       = $clog2(2 * CH_NUM + 2)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [AW-1:0]                    avsAddress,
  input  logic                             avsWr,
  input  logic [31:0]                      avsWrData,
  input  logic                             avsRd,
  output logic [31:0]                      avsRdData,
  input  logic                             smpTick,
  output logic [CH_NUM-1:0][COEF_WDT-1:0]  coef,
  output logic [CH_NUM-1:0]                busy
);

  localparam logic [COEF_WDT-1:0] UNITY_C = COEF_WDT'(unity(COEF_WDT));
  localparam int                  NWORDS  = 2 ** AW;

  logic [CH_NUM-1:0][COEF_WDT-1:0] target_q, target_d;
  logic [COEF_WDT-1:0]             step_q, step_d;
  logic [31:0]                     rd_data_q, rd_data_d;
  logic [COEF_WDT-1:0]             wr_sat_s;
  logic [31:0]                     word_s [NWORDS];

  assign wr_sat_s = COEF_WDT'(sat32(avsWrData, COEF_WDT));

  // Register writes; read-only and unmapped addresses fall through untouched.
  always_comb begin
    for (int i = 0; i < CH_NUM; i++) begin
      if (avsWr && (avsAddress == AW'(tgt_base() + i))) begin
        target_d[i] = wr_sat_s;
      end else begin
        target_d[i] = target_q[i];
      end
    end
    if (avsWr && (avsAddress == AW'(step_addr(CH_NUM)))) begin
      step_d = wr_sat_s;
    end else begin
      step_d = step_q;
    end
  end

  // Full address-space view, zero outside the map, feeding the read capture.
  always_comb begin
    for (int w = 0; w < NWORDS; w++) begin
      word_s[w] = 32'd0;
    end
    for (int i = 0; i < CH_NUM; i++) begin
      word_s[AW'(tgt_base() + i)][COEF_WDT-1:0]        = target_q[i];
      word_s[AW'(live_base(CH_NUM) + i)][COEF_WDT-1:0] = coef[i];
    end
    word_s[AW'(step_addr(CH_NUM))][COEF_WDT-1:0]    = step_q;
    word_s[AW'(status_addr(CH_NUM))][CH_NUM-1:0]    = busy;
    if (avsRd) begin
      rd_data_d = word_s[avsAddress];
    end else begin
      rd_data_d = rd_data_q;
    end
  end

  // Target, step and read-data registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      target_q  <= {CH_NUM{UNITY_C}};
      step_q    <= '0;
      rd_data_q <= 32'd0;
    end else begin
      target_q  <= target_d;
      step_q    <= step_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign avsRdData = rd_data_q;

  for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
    gain_ramp_ch #(
      .COEF_WDT (COEF_WDT)
    ) u_ch (
      .clk     (clk),
      .reset   (reset),
      .target  (target_q[g]),
      .step    (step_q),
      .smpTick (smpTick),
      .live    (coef[g]),
      .busy    (busy[g])
    );
  end

endmodule

// File: tb/tb_gain_avs_ramp.sv
// Directed vector bench for gain_avs_ramp (COEF_WDT=16, CH_NUM=4):
// a table of single-cycle vectors followed by hand-written multi-cycle sequences.
module tb_gain_avs_ramp;

  logic             clk;
  logic             reset;
  logic [3:0]       avsAddress;
  logic             avsWr;
  logic [31:0]      avsWrData;
  logic             avsRd;
  logic [31:0]      avsRdData;
  logic             smpTick;
  logic [3:0][15:0] coef;
  logic [3:0]       busy;

  int n_vec;
  int n_err;

  gain_avs_ramp #(
    .COEF_WDT (16),
    .CH_NUM   (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .avsAddress (avsAddress),
    .avsWr      (avsWr),
    .avsWrData  (avsWrData),
    .avsRd      (avsRd),
    .avsRdData  (avsRdData),
    .smpTick    (smpTick),
    .coef       (coef),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic        rd;
    logic        tick;
    logic [31:0] exp_rd;
    logic [63:0] exp_coef;
    logic [3:0]  exp_busy;
  } vec_t;

  localparam int NV = 40;
  vec_t tbl [NV];

  localparam logic [63:0] UNITY4 = 64'h0100_0100_0100_0100;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, let the posedge take them, settle 1ns after.
  task automatic drive(input logic wr, input logic [3:0] addr, input logic [31:0] wd,
                       input logic rd, input logic tick, input logic rst);
    avsWr = wr; avsAddress = addr; avsWrData = wd; avsRd = rd; smpTick = tick; reset = rst;
    @(posedge clk);
    #1;
    avsWr = 1'b0; avsRd = 1'b0; smpTick = 1'b0; reset = 1'b0;
  endtask

  task automatic chk_all(input string tag, input logic [31:0] er,
                         input logic [63:0] ec, input logic [3:0] eb);
    chk({tag, "_rd"}, 64'(avsRdData), 64'(er));
    chk({tag, "_coef"}, 64'(coef), ec);
    chk({tag, "_busy"}, 64'(busy), 64'(eb));
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    //                wr    addr   wdata          rd    tick  exp_rd        exp_coef                exp_busy
    tbl[0]  = '{1'b0, 4'd8,  32'h0,         1'b1, 1'b0, 32'h0,         UNITY4,                 4'b0000};
    tbl[1]  = '{1'b0, 4'd0,  32'h0,         1'b1, 1'b0, 32'h0100,      UNITY4,                 4'b0000};
    tbl[2]  = '{1'b1, 4'd2,  32'h0001_0000, 1'b0, 1'b0, 32'h0100,      UNITY4,                 4'b0100};
    tbl[3]  = '{1'b0, 4'd2,  32'h0,         1'b1, 1'b0, 32'h0000_FFFF, 64'h0100_FFFF_0100_0100, 4'b0000};
    tbl[4]  = '{1'b1, 4'd2,  32'h0100,      1'b0, 1'b0, 32'h0000_FFFF, 64'h0100_FFFF_0100_0100, 4'b0100};
    tbl[5]  = '{1'b0, 4'd0,  32'h0,         1'b0, 1'b0, 32'h0000_FFFF, UNITY4,                 4'b0000};
    tbl[6]  = '{1'b1, 4'd8,  32'h40,        1'b0, 1'b0, 32'h0000_FFFF, UNITY4,                 4'b0000};
    tbl[7]  = '{1'b1, 4'd0,  32'h0200,      1'b0, 1'b0, 32'h0000_FFFF, UNITY4,                 4'b0001};
    tbl[8]  = '{1'b0, 4'd0,  32'h0,         1'b0, 1'b1, 32'h0000_FFFF, 64'h0100_0100_0100_0140, 4'b0001};
    tbl[9]  = '{1'b0, 4'd0,  32'h0,         1'b0, 1'b1, 32'h0000_FFFF, 64'h0100_0100_0100_0180, 4'b0001};
    tbl[10] = '{1'b0, 4'd0,  32'h0,         1'b0, 1'b0, 32'h0000_FFFF, 64'h0100_0100_0100_0180, 4'b0001};
    tbl[11] = '{1'b0, 4'd0,  32'h0,         1'b0, 1'b1, 32'h0000_FFFF, 64'h0100_0100_0100_01C0, 4'b0001};
    tbl[12] = '{1'b0, 4'd0,  32'h0,         1'b0, 1'b1, 32'h0000_FFFF, 64'h0100_0100_0100_0200, 4'b0000};
    tbl[13] = '{1'b1, 4'd8,  32'h70,        1'b0, 1'b0, 32'h0000_FFFF, 64'h0100_0100_0100_0200, 4'b0000};
    tbl[14] = '{1'b1, 4'd1,  32'h10,        1'b0, 1'b0, 32'h0000_FFFF, 64'h0100_0100_0100_0200, 4'b0010};
    tbl[15] = '{1'b0, 4'd0,  32'h0,         1'b0, 1'b1, 32'h0000_FFFF, 64'h0100_0100_0090_0200, 4'b0010};
    tbl[16] = '{1'b0, 4'd0,  32'h0,         1'b0, 1'b1, 32'h0000_FFFF, 64'h0100_0100_0020_0200, 4'b0010};
    tbl[17] = '{1'b0, 4'd0,  32'h0,         1'b0, 1'b1, 32'h0000_FFFF, 64'h0100_0100_0010_0200, 4'b0000};
    tbl[18] = '{1'b1, 4'd3,  32'h0,         1'b0, 1'b0, 32'h0000_FFFF, 64'h0100_0100_0010_0200, 4'b1000};
    tbl[19] = '{1'b0, 4'd7,  32'h0,         1'b1, 1'b1, 32'h0100,      64'h0090_0100_0010_0200, 4'b1000};
    tbl[20] = '{1'b0, 4'd9,  32'h0,         1'b1, 1'b1, 32'h0008,      64'h0020_0100_0010_0200, 4'b1000};
    tbl[21] = '{1'b1, 4'd5,  32'h1234,      1'b1, 1'b0, 32'h0010,      64'h0020_0100_0010_0200, 4'b1000};
    tbl[22] = '{1'b0, 4'd5,  32'h0,         1'b1, 1'b0, 32'h0010,      64'h0020_0100_0010_0200, 4'b1000};
    tbl[23] = '{1'b0, 4'd4,  32'h0,         1'b1, 1'b0, 32'h0200,      64'h0020_0100_0010_0200, 4'b1000};
    tbl[24] = '{1'b0, 4'd6,  32'h0,         1'b1, 1'b0, 32'h0100,      64'h0020_0100_0010_0200, 4'b1000};
    tbl[25] = '{1'b0, 4'd15, 32'h0,         1'b1, 1'b1, 32'h0,         64'h0000_0100_0010_0200, 4'b0000};
    tbl[26] = '{1'b1, 4'd10, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0,         64'h0000_0100_0010_0200, 4'b0000};
    tbl[27] = '{1'b0, 4'd8,  32'h0,         1'b1, 1'b0, 32'h0070,      64'h0000_0100_0010_0200, 4'b0000};
    tbl[28] = '{1'b0, 4'd3,  32'h0,         1'b1, 1'b0, 32'h0,         64'h0000_0100_0010_0200, 4'b0000};
    tbl[29] = '{1'b0, 4'd9,  32'h0,         1'b1, 1'b0, 32'h0,         64'h0000_0100_0010_0200, 4'b0000};
    tbl[30] = '{1'b1, 4'd8,  32'h0002_0000, 1'b0, 1'b0, 32'h0,         64'h0000_0100_0010_0200, 4'b0000};
    tbl[31] = '{1'b0, 4'd8,  32'h0,         1'b1, 1'b0, 32'h0000_FFFF, 64'h0000_0100_0010_0200, 4'b0000};
    tbl[32] = '{1'b1, 4'd8,  32'h30,        1'b1, 1'b0, 32'h0000_FFFF, 64'h0000_0100_0010_0200, 4'b0000};
    tbl[33] = '{1'b0, 4'd8,  32'h0,         1'b1, 1'b0, 32'h0030,      64'h0000_0100_0010_0200, 4'b0000};
    tbl[34] = '{1'b0, 4'd11, 32'h0,         1'b1, 1'b0, 32'h0,         64'h0000_0100_0010_0200, 4'b0000};
    tbl[35] = '{1'b0, 4'd0,  32'h0,         1'b1, 1'b0, 32'h0200,      64'h0000_0100_0010_0200, 4'b0000};
    tbl[36] = '{1'b0, 4'd12, 32'h0,         1'b1, 1'b0, 32'h0,         64'h0000_0100_0010_0200, 4'b0000};
    tbl[37] = '{1'b0, 4'd1,  32'h0,         1'b1, 1'b0, 32'h0010,      64'h0000_0100_0010_0200, 4'b0000};
    tbl[38] = '{1'b0, 4'd13, 32'h0,         1'b1, 1'b0, 32'h0,         64'h0000_0100_0010_0200, 4'b0000};
    tbl[39] = '{1'b0, 4'd14, 32'h0,         1'b1, 1'b0, 32'h0,         64'h0000_0100_0010_0200, 4'b0000};

    avsWr = 1'b0; avsRd = 1'b0; avsAddress = 4'd0; avsWrData = 32'd0; smpTick = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    drive(1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    chk_all("reset", 32'h0, UNITY4, 4'b0000);

    for (int v = 0; v < NV; v++) begin
      drive(tbl[v].wr, tbl[v].addr, tbl[v].wdata, tbl[v].rd, tbl[v].tick, 1'b0);
      chk_all($sformatf("vec%0d", v), tbl[v].exp_rd, tbl[v].exp_coef, tbl[v].exp_busy);
    end

    // Write coinciding with a tick: the ramp still sees the old target (0x200 == live).
    drive(1'b1, 4'd0, 32'h0100, 1'b0, 1'b1, 1'b0);
    chk("wr_tick_coef", 64'(coef), 64'h0000_0100_0010_0200);
    chk("wr_tick_busy", 64'(busy), 64'h1);
    drive(1'b0, 4'd0, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("ramp_b_coef", 64'(coef), 64'h0000_0100_0010_01D0);
    drive(1'b0, 4'd0, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("ramp_c_coef", 64'(coef), 64'h0000_0100_0010_01A0);

    // Reset mid-ramp, together with a write and a tick.
    drive(1'b1, 4'd0, 32'h0300, 1'b1, 1'b1, 1'b1);
    chk_all("mid_reset", 32'h0, UNITY4, 4'b0000);
    drive(1'b0, 4'd0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("post_reset_tgt0", 64'(avsRdData), 64'h0100);

    // Step=0 written mid-ramp snaps two cycles after the write.
    drive(1'b1, 4'd8, 32'h30, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 4'd0, 32'h0300, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 4'd0, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("snap_ramp_coef", 64'(coef), 64'h0100_0100_0100_0130);
    drive(1'b1, 4'd8, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("snap_wr_coef", 64'(coef), 64'h0100_0100_0100_0130);
    drive(1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("snap_done_coef", 64'(coef), 64'h0100_0100_0100_0300);
    chk("snap_done_busy", 64'(busy), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/gain_avs_ramp.md
# gain_avs_ramp

Multi-channel Avalon-MM gain coefficient bank with per-sample coefficient ramping. This block generalises the single-coefficient gain register. It holds CH_NUM target coefficients, one shared ramp step and CH_NUM live coefficients. On each sample tick, every live coefficient moves toward its target to avoid zipper noise. It sits between the Avalon-MM interconnect and the per-channel gain multipliers.

## Interface
- COEF_WDT, 16, coefficient width; even, 2..32; format ufi(COEF_WDT, COEF_WDT/2)
- CH_NUM, 4, channel count, 1..16
- AW, $clog2(2*CH_NUM+2), address width (derived, not overridden)

- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset; one clock; sampled on posedge clk
- avsAddress  in  AW  word address
- avsWr  in  1  write strobe
- avsWrData  in  32  write data
- avsRd  in  1  read strobe
- avsRdData  out  32  read data, fixed latency 1
- smpTick  in  1  one-cycle sample strobe; advances ramps
- coef  out  CH_NUM×COEF_WDT  live coefficients, packed [CH_NUM-1:0][COEF_WDT-1:0]
- busy  out  CH_NUM  bit i = channel i live ≠ target

## Operation
- Address map:
  - 0..CH_NUM-1: target[i], R/W.
  - CH_NUM..2*CH_NUM-1: live coef[i], read-only.
  - 2*CH_NUM: step, R/W.
  - 2*CH_NUM+1: status, read-only; busy zero-extended.
  - All other addresses read 0.
- Write saturation, for target and step:
  - If COEF_WDT<32 and any of avsWrData[31:COEF_WDT] is set, the stored value is all ones.
  - Otherwise the stored value is avsWrData[COEF_WDT-1:0].
- Writes to read-only or unmapped addresses are ignored.
- Reset values:
  - Every target and every live coef = 2^(COEF_WDT/2) (unity).
  - step = 0.
  - avsRdData = 0.
  - busy = 0.
- Ramp rule per channel, evaluated each cycle using registered values:
  - step==0 (immediate mode): live <= target every cycle, independent of smpTick.
  - step>0 and smpTick=1: if |target−live| ≤ step, then live <= target; else live moves by ±step toward target.
  - step>0 and smpTick=0: live holds.
- Ramp arithmetic uses COEF_WDT+1 bits for the difference. live never overshoots and never wraps, including at target = 0 and target = all ones.
- busy[i] = (live[i] != target[i]), decoded from registers only. There is no combinational path from any input to busy.
- avsRdData captures the mapped value when avsRd=1 and holds otherwise.

## Timing
- Write at cycle n: the target or step register is updated at n+1.
- Read at cycle n: avsRdData is valid at n+1 and shows register contents as of cycle n. A write to the same address in cycle n is not visible to that read.
- Simultaneous write and smpTick in cycle n: the ramp in cycle n uses the old target and old step. The new values take effect from n+1.
- Immediate mode: a write at n gives coef at n+2.
- Ramp mode: the first step lands on the cycle after the first smpTick at or after n+1. Full convergence takes ceil(|Δ|/step) ticks.
- A target rewrite mid-ramp redirects the ramp from the current live value. There is no restart from the old target.
- Writing step=0 mid-ramp snaps every channel to its target 2 cycles after the write.
- Reset asserted mid-ramp: all registers return to reset values on the next posedge; ramps are abandoned.
- smpTick asserted on consecutive cycles is legal: one step per cycle.

## Structure
- Package gain_pkg:
  - Function unity(COEF_WDT).
  - Saturation function sat32(data, COEF_WDT).
  - Address-offset helper functions for the TGT, LIVE, STEP and STATUS bases, parameterised by CH_NUM.
- Sub-module gain_ramp_ch: holds one channel's live register and ramp arithmetic.
  - Inputs: target, step, smpTick, clk, reset.
  - Outputs: live, busy.
  - Instantiated CH_NUM times in a generate loop.
- The top level holds the target, step and read-mux registers.

## Test plan
- Reset with COEF_WDT=16, CH_NUM=4 -> all coef = 0x0100, busy = 0, reading address 8 (step) returns 0.
- Write target[2] = 0x0001_0000 (saturating) in immediate mode -> read address 2 returns 0x0000_FFFF; coef[2] = 0xFFFF at n+2.
- Step = 0x40, target[0] = 0x0200, 4 ticks -> coef[0] goes 0x0140, 0x0180, 0x01C0, 0x0200; busy[0] clears after the 4th tick.
- Step = 0x70, target[1] = 0x0010 (down) -> coef[1] goes 0x0090, then 0x0020, then 0x0010 (clamped, no wrap) on the 3rd tick.
- Target write coinciding with smpTick, then reset asserted mid-ramp -> the ramp step uses the old target; after reset, everything returns to unity within one cycle.
- Read addresses 4..7 and 9 during a ramp; write address 5; read unmapped addresses 10..15 -> addresses 4..7 return live values and 9 returns the busy mask; the write to 5 is ignored; 10..15 return 0.
